// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter:
// FSM state encodings, requester IDs and the address/data width.
package mem_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/dff.sv
// Team register cell: W-bit D flip-flop with synchronous active-high reset.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every edge; reset forces RST_VAL.
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between two requesters.
// On a tie the requester that did not own last (per last_gnt) wins;
// with last_gnt tied low this degenerates to fixed priority for requester 1.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner
);

    // Lone requester wins outright; a tie goes to the one not in last_gnt.
    always_comb begin
        winner = REQ_ID0;
        if (req0 && req1) winner = (last_gnt == REQ_ID1) ? REQ_ID0 : REQ_ID1;
        else if (req1)    winner = REQ_ID1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (instruction side = 0, data side = 1).
// Ownership is held for a whole burst; release passes through DRAIN,
// which waits for all memory banks to go idle before a new grant.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise requester 1 wins every tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [3:0]        busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              stall1
);

    logic [1:0] state_raw;
    state_t     state_q;
    state_t     state_d;
    logic       winner;
    logic       last_gnt;

    // State register.
    dff #(.W(2), .RST_VAL(2'(ST_IDLE))) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_raw)
    );

    assign state_q = state_t'(state_raw);

`ifdef MEM_ARB_RR_EN
    logic last_gnt_d;

    // Remember the owner each time a grant is issued out of IDLE.
    always_comb begin
        last_gnt_d = last_gnt;
        if (state_q == ST_IDLE && (req0 || req1)) last_gnt_d = winner;
    end

    dff #(.W(1), .RST_VAL(1'b0)) u_last_gnt_reg (
        .clk (clk),
        .rst (rst),
        .d   (last_gnt_d),
        .q   (last_gnt)
    );
`else
    assign last_gnt = 1'b0;
`endif

    mem_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

    // Next-state: grant from IDLE, hold while owner requests, drain until banks idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req0 || req1) state_d = (winner == REQ_ID1) ? ST_OWN1 : ST_OWN0;
            ST_OWN0:  if (!req0) state_d = ST_DRAIN;
            ST_OWN1:  if (!req1) state_d = ST_DRAIN;
            ST_DRAIN: if (busy == 4'b0000) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: owner's request is routed to memory; write wins over read;
    // strobes are gated by the owner's req so a releasing owner issues nothing.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_OWN0: begin
                gnt0      = 1'b1;
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_wr    = wr0 & req0;
                mem_rd    = rd0 & ~wr0 & req0;
            end
            ST_OWN1: begin
                gnt1      = 1'b1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_wr    = wr1 & req1;
                mem_rd    = rd1 & ~wr1 & req1;
            end
            default: ;
        endcase
        stall0 = req0 & ~gnt0;
        stall1 = req1 & ~gnt1;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Status bits are compared as
// {gnt0, gnt1, stall0, stall1, mem_rd, mem_wr}.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0, rd0, wr0, req1, rd1, wr1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  busy;
    logic        mem_rd, mem_wr, gnt0, gnt1, stall0, stall1;
    logic [15:0] mem_addr, mem_wdata;
    logic [5:0]  st;

    int vec_cnt;
    int err_cnt;

    assign st = {gnt0, gnt1, stall0, stall1, mem_rd, mem_wr};

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .busy(busy),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        busy = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        vec_cnt++;
        if (st !== 6'b000000) begin err_cnt++; $display("FAIL reset_status: got %b expected %b", st, 6'b000000); end
        vec_cnt++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin err_cnt++; $display("FAIL reset_bus: got %h expected %h", {mem_addr, mem_wdata}, 32'h0); end
        req0 = 1; req1 = 1; rd0 = 1; addr0 = 16'h1234; wdata0 = 16'h5678;
        #1;
        vec_cnt++;
        if (st !== 6'b001100) begin err_cnt++; $display("FAIL reset_stall_eq_req: got %b expected %b", st, 6'b001100); end
        tick();
        vec_cnt++;
        if (st !== 6'b001100) begin err_cnt++; $display("FAIL reset_held_status: got %b expected %b", st, 6'b001100); end
        vec_cnt++;
        if (dut.state_q !== ST_IDLE) begin err_cnt++; $display("FAIL reset_held_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        rst = 0;
        clear_inputs();
        #1;
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; rd0 = 1; addr0 = 16'h0040; wdata0 = 16'h1111;
        #1;
        vec_cnt++;
        if (st !== 6'b001000 || mem_addr !== 16'h0000) begin err_cnt++; $display("FAIL read_pre_grant: got %b/%h expected %b/%h", st, mem_addr, 6'b001000, 16'h0000); end
        tick();
        vec_cnt++;
        if (st !== 6'b100010 || mem_addr !== 16'h0040) begin err_cnt++; $display("FAIL read_grant: got %b/%h expected %b/%h", st, mem_addr, 6'b100010, 16'h0040); end
        req0 = 0;
        #1;
        vec_cnt++;
        if (st !== 6'b100000) begin err_cnt++; $display("FAIL read_release_no_strobe: got %b expected %b", st, 6'b100000); end
        tick();
        vec_cnt++;
        if (st !== 6'b000000 || dut.state_q !== ST_DRAIN) begin err_cnt++; $display("FAIL read_drain: got %b/%0d expected %b/%0d", st, dut.state_q, 6'b000000, ST_DRAIN); end
        tick();
        vec_cnt++;
        if (dut.state_q !== ST_IDLE) begin err_cnt++; $display("FAIL read_back_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_tie();
        logic [5:0] exp_second;
        do_reset();
        req0 = 1; req1 = 1;
        tick();
        vec_cnt++;
        if (st !== 6'b011000) begin err_cnt++; $display("FAIL tie_first: got %b expected %b", st, 6'b011000); end
        req0 = 0; req1 = 0;
        tick();
        tick();
        req0 = 1; req1 = 1;
        tick();
`ifdef MEM_ARB_RR_EN
        exp_second = 6'b100100;
`else
        exp_second = 6'b011000;
`endif
        vec_cnt++;
        if (st !== exp_second) begin err_cnt++; $display("FAIL tie_second: got %b expected %b", st, exp_second); end
        clear_inputs();
    endtask

    task automatic test_burst_drain();
        do_reset();
        req1 = 1; rd1 = 1; addr1 = 16'h0100;
        tick();
        vec_cnt++;
        if (st !== 6'b010010 || mem_addr !== 16'h0100) begin err_cnt++; $display("FAIL burst_c1: got %b/%h expected %b/%h", st, mem_addr, 6'b010010, 16'h0100); end
        req0 = 1;
        for (int i = 1; i < 4; i++) begin
            addr1 = 16'h0100 + 16'(i);
            tick();
            vec_cnt++;
            if (st !== 6'b011010 || mem_addr !== 16'h0100 + 16'(i)) begin
                err_cnt++; $display("FAIL burst_c%0d: got %b/%h expected %b/%h", i + 1, st, mem_addr, 6'b011010, 16'h0100 + 16'(i));
            end
        end
        req1 = 0; busy = 4'b0010;
        #1;
        vec_cnt++;
        if (st !== 6'b011000) begin err_cnt++; $display("FAIL burst_release: got %b expected %b", st, 6'b011000); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vec_cnt++;
            if (st !== 6'b001000 || dut.state_q !== ST_DRAIN) begin
                err_cnt++; $display("FAIL drain_c%0d: got %b/%0d expected %b/%0d", i, st, dut.state_q, 6'b001000, ST_DRAIN);
            end
        end
        busy = 4'b0000;
        tick();
        vec_cnt++;
        if (st !== 6'b001000 || dut.state_q !== ST_IDLE) begin err_cnt++; $display("FAIL drain_to_idle: got %b/%0d expected %b/%0d", st, dut.state_q, 6'b001000, ST_IDLE); end
        tick();
        vec_cnt++;
        if (st !== 6'b100000) begin err_cnt++; $display("FAIL drain_then_gnt0: got %b expected %b", st, 6'b100000); end
        clear_inputs();
    endtask

    task automatic test_rw_write();
        do_reset();
        req1 = 1; rd1 = 1; wr1 = 1; wdata1 = 16'hBEEF; addr1 = 16'h2000;
        #1;
        vec_cnt++;
        if (mem_wdata !== 16'h0000) begin err_cnt++; $display("FAIL write_pre_grant_wdata: got %h expected %h", mem_wdata, 16'h0000); end
        tick();
        vec_cnt++;
        if (st !== 6'b010001) begin err_cnt++; $display("FAIL write_only_status: got %b expected %b", st, 6'b010001); end
        vec_cnt++;
        if ({mem_addr, mem_wdata} !== {16'h2000, 16'hBEEF}) begin err_cnt++; $display("FAIL write_bus: got %h expected %h", {mem_addr, mem_wdata}, {16'h2000, 16'hBEEF}); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req0 = 1; rd0 = 1; addr0 = 16'h0080;
        tick();
        vec_cnt++;
        if (st !== 6'b100010) begin err_cnt++; $display("FAIL midrst_own: got %b expected %b", st, 6'b100010); end
        tick();
        rst = 1;
        tick();
        vec_cnt++;
        if (st !== 6'b001000 || dut.state_q !== ST_IDLE) begin err_cnt++; $display("FAIL midrst_abort: got %b/%0d expected %b/%0d", st, dut.state_q, 6'b001000, ST_IDLE); end
        rst = 0;
        tick();
        vec_cnt++;
        if (st !== 6'b100010 || mem_addr !== 16'h0080) begin err_cnt++; $display("FAIL midrst_regrant: got %b/%h expected %b/%h", st, mem_addr, 6'b100010, 16'h0080); end
        clear_inputs();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_burst_drain();
        test_rw_write();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
